// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-stage register indices and control in,
// forwarding selects, stall/flush controls and the stall counter out.
interface hazard_ctrl_if #(
    parameter int W = 16
);
    logic [4:0]   Rs1D;
    logic [4:0]   Rs2D;
    logic [4:0]   Rs1E;
    logic [4:0]   Rs2E;
    logic [4:0]   RdE;
    logic [4:0]   RdM;
    logic [4:0]   RdW;
    logic         RegWriteM;
    logic         RegWriteW;
    logic         MemReadE;
    logic         PCSrcE;
    logic         MulDivStartE;
    logic         MulDivDoneX;
    logic [1:0]   ForwardAE;
    logic [1:0]   ForwardBE;
    logic         StallF;
    logic         StallD;
    logic         StallE;
    logic         FlushD;
    logic         FlushE;
    logic         FlushM;
    logic [W-1:0] StallCount;
    logic [4:0]   busy_rd;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, MemReadE, PCSrcE,
        output MulDivStartE, MulDivDoneX,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM,
        input  StallCount, busy_rd
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, MemReadE, PCSrcE,
        input  MulDivStartE, MulDivDoneX,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE,
        output FlushD, FlushE, FlushM,
        output StallCount, busy_rd
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use / branch hazards,
// multi-cycle mul/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state;
    state_t       state_next;
    logic [4:0]   busy_rd;
    logic [W-1:0] stall_count;
    logic         lw_stall;
    logic         md_stall;
    logic         start_multi;
    logic [1:0]   fwd_a;
    logic [1:0]   fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM,
                           bus.RdW, bus.RegWriteW);
    assign fwd_b = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM,
                           bus.RdW, bus.RegWriteW);

    assign lw_stall = bus.MemReadE && bus.RdE != 5'd0 &&
                      (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);

    // Start with done in the same cycle is a single-cycle op: no BUSY.
    assign start_multi = bus.MulDivStartE && !bus.MulDivDoneX;

    assign md_stall = (state == IDLE && start_multi) ||
                      (state == BUSY && !bus.MulDivDoneX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_rd <= 5'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_multi)
                busy_rd <= bus.RdE;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_multi) state_next = BUSY;
            BUSY: if (bus.MulDivDoneX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ForwardAE = fwd_a;
        bus.ForwardBE = fwd_b;
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.StallE    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.FlushM    = 1'b0;
        if (rst) begin
            bus.ForwardAE = 2'b00;
            bus.ForwardBE = 2'b00;
            bus.FlushD    = 1'b1;
            bus.FlushE    = 1'b1;
            bus.FlushM    = 1'b1;
        end else if (md_stall) begin
            // E holds the mul/div, so branch and load-use are irrelevant.
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.StallE = 1'b1;
            bus.FlushM = 1'b1;
        end else begin
            bus.StallF = lw_stall;
            bus.StallD = lw_stall;
            bus.FlushD = bus.PCSrcE;
            bus.FlushE = lw_stall || bus.PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (bus.StallF && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

    assign bus.StallCount = stall_count;
    assign bus.busy_rd    = busy_rd;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, mul/div,
// reset during BUSY, and counter saturation on a W=4 instance.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.W(16)) hif ();
    hazard_ctrl_if #(.W(4))  hsat ();

    hazard_ctrl #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    hazard_ctrl #(.W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (hsat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.RegWriteM = 0; hif.RegWriteW = 0; hif.MemReadE = 0;
        hif.PCSrcE = 0; hif.MulDivStartE = 0; hif.MulDivDoneX = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
    function automatic logic [5:0] ctl();
        return {hif.StallF, hif.StallD, hif.StallE,
                hif.FlushD, hif.FlushE, hif.FlushM};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        clear_inputs();
        hsat.Rs1D = 0; hsat.Rs2D = 0; hsat.Rs1E = 0; hsat.Rs2E = 0;
        hsat.RdE = 0; hsat.RdM = 0; hsat.RdW = 0;
        hsat.RegWriteM = 0; hsat.RegWriteW = 0; hsat.MemReadE = 0;
        hsat.PCSrcE = 0; hsat.MulDivStartE = 0; hsat.MulDivDoneX = 0;
        rst = 1'b1;

        // Reset: flushes high, no stalls, forwarding masked
        hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1;
        hif.Rs2E = 6; hif.RdW = 6; hif.RegWriteW = 1;
        step();
        check("rst_ctl", ctl(), 6'b000111);
        check("rst_fwd_a", hif.ForwardAE, 2'b00);
        check("rst_fwd_b", hif.ForwardBE, 2'b00);
        step();
        check("rst_count", hif.StallCount, 0);
        check("rst_busy_rd", hif.busy_rd, 0);

        rst = 1'b0;
        clear_inputs();

        // Forwarding priority
        hif.RdM = 5; hif.RdW = 5; hif.RegWriteM = 1; hif.RegWriteW = 1;
        hif.Rs1E = 5; hif.Rs2E = 3;
        step();
        check("fwd_m_wins", hif.ForwardAE, 2'b10);
        check("fwd_b_none", hif.ForwardBE, 2'b00);
        check("fwd_ctl_idle", ctl(), 6'b000000);
        hif.RegWriteM = 0; hif.Rs2E = 5;
        step();
        check("fwd_w_a", hif.ForwardAE, 2'b01);
        check("fwd_w_b", hif.ForwardBE, 2'b01);
        hif.RegWriteM = 1; hif.RdM = 5; hif.RdW = 9; hif.Rs2E = 9;
        step();
        check("fwd_split_a", hif.ForwardAE, 2'b10);
        check("fwd_split_b", hif.ForwardBE, 2'b01);
        hif.RdM = 0; hif.RdW = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        step();
        check("fwd_x0_a", hif.ForwardAE, 2'b00);
        check("fwd_x0_b", hif.ForwardBE, 2'b00);
        clear_inputs();

        // Load-use
        hif.MemReadE = 1; hif.RdE = 7; hif.Rs2D = 7; hif.Rs1D = 2;
        step();
        check("lw_ctl", ctl(), 6'b110010);
        hif.MemReadE = 0;
        step();
        check("lw_release", ctl(), 6'b000000);
        check("lw_count", hif.StallCount, 1);
        hif.MemReadE = 1; hif.RdE = 0; hif.Rs1D = 0; hif.Rs2D = 0;
        step();
        check("lw_x0", ctl(), 6'b000000);
        clear_inputs();

        // Branch, then branch together with load-use
        hif.PCSrcE = 1;
        step();
        check("br_ctl", ctl(), 6'b000110);
        hif.MemReadE = 1; hif.RdE = 4; hif.Rs1D = 4;
        step();
        check("br_lw_ctl", ctl(), 6'b110110);
        clear_inputs();
        step();
        check("br_count", hif.StallCount, 2);

        // Start and done together: single-cycle op, no stall
        hif.MulDivStartE = 1; hif.MulDivDoneX = 1;
        step();
        check("md_1cyc", ctl(), 6'b000000);
        clear_inputs();
        step();
        check("md_1cyc_idle", ctl(), 6'b000000);

        // Mul/div latency 4
        hif.MulDivStartE = 1; hif.RdE = 9;
        step();
        check("md_c0", ctl(), 6'b111001);
        hif.MulDivStartE = 0; hif.RdE = 0;
        hif.PCSrcE = 1; hif.MemReadE = 1; hif.RdE = 3; hif.Rs1D = 3;
        step();
        check("md_c1_ignore", ctl(), 6'b111001);
        check("md_busy_rd", hif.busy_rd, 9);
        clear_inputs();
        for (int i = 2; i < 4; i++) begin
            step();
            check($sformatf("md_c%0d", i), ctl(), 6'b111001);
        end
        hif.MulDivDoneX = 1;
        step();
        check("md_done", ctl(), 6'b000000);
        hif.MulDivDoneX = 0;
        step();
        check("md_idle", ctl(), 6'b000000);
        check("md_count", hif.StallCount, 6);

        // Reset on the 2nd BUSY cycle
        hif.MulDivStartE = 1; hif.RdE = 12;
        step();
        hif.MulDivStartE = 0; hif.RdE = 0;
        step();
        check("rb_busy1", ctl(), 6'b111001);
        rst = 1'b1;
        step();
        check("rb_rst_ctl", ctl(), 6'b000111);
        rst = 1'b0;
        step();
        check("rb_after_ctl", ctl(), 6'b000000);
        check("rb_after_cnt", hif.StallCount, 0);
        check("rb_after_rd", hif.busy_rd, 0);
        hif.MulDivDoneX = 1;
        step();
        check("rb_done_idle", ctl(), 6'b000000);
        hif.MulDivDoneX = 0;
        step();
        check("rb_still_idle", ctl(), 6'b000000);
        check("rb_cnt_hold", hif.StallCount, 0);

        // Saturation on the W=4 instance: 20 stall cycles
        hsat.MulDivStartE = 1;
        step();
        hsat.MulDivStartE = 0;
        for (int i = 1; i < 20; i++) begin
            step();
            check($sformatf("sat_stall%0d", i), hsat.StallF, 1'b1);
        end
        step();
        check("sat_count", hsat.StallCount, 4'hF);
        hsat.MulDivDoneX = 1;
        step();
        check("sat_release", hsat.StallF, 1'b0);
        hsat.MulDivDoneX = 0;
        step();
        check("sat_hold", hsat.StallCount, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
